// File: rtl/s_core_loader_pkg.sv
// Shared constants and types for the s_core program loader.
// Optional trailing checksum byte per frame: define S_CORE_LOADER_CHECKSUM_EN.
package s_core_loader_pkg;

  // Frame opcodes (first byte of each frame)
  localparam logic [7:0] CMD_IMEM  = 8'h01;
  localparam logic [7:0] CMD_REG   = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;

  // Field lengths in bytes
  localparam int WORD_BYTES    = 4;
  localparam int REG_IDX_BYTES = 1;

  // Loader state encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_START = 3'd4,
    ST_RUN   = 3'd5,
    ST_CSUM  = 3'd6
  } state_t;

  function automatic logic is_known_cmd(input logic [7:0] b);
    return (b == CMD_IMEM) || (b == CMD_REG) || (b == CMD_START);
  endfunction

endpackage

// File: rtl/s_core_loader_shift.sv
// Little-endian 32-bit byte assembler. Byte n of a field lands in bits
// [8n+7:8n]. o_word already includes the byte being shifted in this cycle
// so the caller can capture a complete field on the accepting edge.
module ld_word_shift
  import s_core_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_shift_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [1:0]  o_byte_idx,
  output logic        o_done
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic [31:0] w_word;

  // Merge the incoming byte into its lane
  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    assign w_word[gi*8 +: 8] = (i_shift_en && (r_idx == 2'(gi))) ? i_byte : r_word[gi*8 +: 8];
  end

  // Hold the partial word and the next byte position; clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_shift_en) begin
      r_word <= w_word;
      r_idx  <= r_idx + 2'd1;
    end
  end

  assign o_word     = w_word;
  assign o_byte_idx = r_idx;
  assign o_done     = i_shift_en && (r_idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/s_core_loader.sv
// s_core setup-side loader: decodes IMEM/REG/START frames from a byte
// stream and drives the core's load interface, holding the core in setup
// until a START frame. Optional trailing XOR checksum per frame when
// S_CORE_LOADER_CHECKSUM_EN is defined.
module s_core_loader
  import s_core_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES   = 1024,
  parameter logic [31:0] RESET_START_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  input  logic        i_reload,
  output logic        o_setup,
  output logic [31:0] o_inst_mem_addr,
  output logic [31:0] o_inst_mem_data,
  output logic        o_inst_mem_we,
  output logic [4:0]  o_load_reg_addr,
  output logic [31:0] o_load_reg_data,
  output logic        o_load_reg_we,
  output logic [31:0] o_pc_instr_start_addr,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_frame_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_next;
  logic [7:0]  r_cmd;
  logic [31:0] r_addr, r_data;
  logic [CNT_W-1:0] r_idle_cnt;
  logic        r_err;
  logic [15:0] r_frame_count;
  logic [31:0] r_pc, r_inst_addr, r_inst_data, r_reg_data;
  logic [4:0]  r_reg_addr;

  logic        w_rx_ready, w_accept, w_collect, w_timeout, w_err_set;
  logic        w_addr_done, w_data_done, w_sh_clear, w_sh_shift, w_sh_done;
  logic [31:0] w_word, w_addr_field, w_data_field;
  logic [1:0]  w_byte_idx;

  assign w_rx_ready = !((r_state == ST_ISSUE) || (r_state == ST_START) || (r_state == ST_RUN));
  assign w_accept   = i_rx_valid && w_rx_ready;
`ifdef S_CORE_LOADER_CHECKSUM_EN
  assign w_collect  = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CSUM);
`else
  assign w_collect  = (r_state == ST_ADDR) || (r_state == ST_DATA);
`endif
  // Abort on the TIMEOUT_CYCLES-th consecutive cycle with no accepted byte
  assign w_timeout  = w_collect && !w_accept && (r_idle_cnt == TMO_LAST);

  // REG index is a single byte; IMEM/START addresses are full words
  assign w_addr_done = (r_state == ST_ADDR) && w_accept &&
                       ((r_cmd == CMD_REG) ? (w_byte_idx == 2'(REG_IDX_BYTES - 1)) : w_sh_done);
  assign w_data_done = (r_state == ST_DATA) && w_sh_done;
  assign w_sh_shift  = w_accept && ((r_state == ST_ADDR) || (r_state == ST_DATA));
  assign w_sh_clear  = (r_state == ST_IDLE) || w_addr_done || i_reload;

  // Fields are taken straight from the assembler when the frame completes on
  // the last payload byte, otherwise from the captured copy (checksum path)
  assign w_addr_field = (r_state == ST_ADDR) ? w_word : r_addr;
  assign w_data_field = (r_state == ST_DATA) ? w_word : r_data;

  ld_word_shift u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_sh_clear),
    .i_shift_en (w_sh_shift),
    .i_byte     (i_rx_data),
    .o_word     (w_word),
    .o_byte_idx (w_byte_idx),
    .o_done     (w_sh_done)
  );

`ifdef S_CORE_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  // Running XOR of every accepted frame byte, restarted by the opcode
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_csum <= '0;
    else if (w_accept) r_csum <= (r_state == ST_IDLE) ? i_rx_data : (r_csum ^ i_rx_data);
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode; reload overrides everything
  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        if (is_known_cmd(i_rx_data)) w_state_next = ST_ADDR;
        else                         w_err_set    = 1'b1;
      end
      ST_ADDR: if (w_timeout) begin
        w_state_next = ST_IDLE;
        w_err_set    = 1'b1;
      end else if (w_addr_done) begin
`ifdef S_CORE_LOADER_CHECKSUM_EN
        w_state_next = (r_cmd == CMD_START) ? ST_CSUM : ST_DATA;
`else
        w_state_next = (r_cmd == CMD_START) ? ST_START : ST_DATA;
`endif
      end
      ST_DATA: if (w_timeout) begin
        w_state_next = ST_IDLE;
        w_err_set    = 1'b1;
      end else if (w_data_done) begin
`ifdef S_CORE_LOADER_CHECKSUM_EN
        w_state_next = ST_CSUM;
`else
        w_state_next = ST_ISSUE;
`endif
      end
`ifdef S_CORE_LOADER_CHECKSUM_EN
      ST_CSUM: if (w_timeout) begin
        w_state_next = ST_IDLE;
        w_err_set    = 1'b1;
      end else if (w_accept) begin
        if (i_rx_data == r_csum) begin
          w_state_next = (r_cmd == CMD_START) ? ST_START : ST_ISSUE;
        end else begin
          w_state_next = ST_IDLE;
          w_err_set    = 1'b1;
        end
      end
`endif
      ST_ISSUE: w_state_next = ST_IDLE;
      ST_START: w_state_next = ST_RUN;
      ST_RUN:   w_state_next = ST_RUN;
      default:  w_state_next = ST_IDLE;
    endcase
    if (i_reload) begin
      w_state_next = ST_IDLE;
      w_err_set    = 1'b0;
    end
  end

  // Opcode and field capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd  <= '0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_accept) r_cmd  <= i_rx_data;
      if (w_addr_done)                      r_addr <= w_word;
      if (w_data_done)                      r_data <= w_word;
    end
  end

  // Inter-byte idle counter, only running mid-frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_idle_cnt <= '0;
    else if (!w_collect || w_accept || i_reload || w_timeout) r_idle_cnt <= '0;
    else                                       r_idle_cnt <= r_idle_cnt + 1'b1;
  end

  // Load-interface registers, error flag and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_addr   <= '0;
      r_inst_data   <= '0;
      r_reg_addr    <= '0;
      r_reg_data    <= '0;
      r_pc          <= RESET_START_ADDR;
      r_err         <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_state_next == ST_ISSUE) begin
        if (r_cmd == CMD_IMEM) begin
          r_inst_addr <= w_addr_field;
          r_inst_data <= w_data_field;
        end
        if (r_cmd == CMD_REG) begin
          r_reg_addr <= w_addr_field[4:0];
          r_reg_data <= w_data_field;
        end
      end
      if (w_state_next == ST_START) r_pc <= w_addr_field;
      if ((w_state_next == ST_ISSUE) || (w_state_next == ST_START))
        r_frame_count <= r_frame_count + 16'd1;
      if (i_reload)       r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
    end
  end

  assign o_rx_ready            = w_rx_ready;
  assign o_setup               = (r_state != ST_RUN);
  assign o_busy                = w_collect || (r_state == ST_ISSUE) || (r_state == ST_START);
  assign o_inst_mem_addr       = r_inst_addr;
  assign o_inst_mem_data       = r_inst_data;
  assign o_inst_mem_we         = (r_state == ST_ISSUE) && (r_cmd == CMD_IMEM);
  assign o_load_reg_addr       = r_reg_addr;
  assign o_load_reg_data       = r_reg_data;
  // Register 0 is hardwired in the core, so its write strobe is suppressed
  assign o_load_reg_we         = (r_state == ST_ISSUE) && (r_cmd == CMD_REG) && (r_reg_addr != 5'd0);
  assign o_pc_instr_start_addr = r_pc;
  assign o_err                 = r_err;
  assign o_frame_count         = r_frame_count;

endmodule

// File: tb/tb_s_core_loader.sv
// Scoreboard bench for s_core_loader. Works with or without
// S_CORE_LOADER_CHECKSUM_EN (frames get their XOR byte appended).
module tb_s_core_loader;

  localparam int          T   = 40;
  localparam logic [31:0] RSA = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        i_reload;
  logic        o_setup;
  logic [31:0] o_inst_mem_addr, o_inst_mem_data;
  logic        o_inst_mem_we;
  logic [4:0]  o_load_reg_addr;
  logic [31:0] o_load_reg_data;
  logic        o_load_reg_we;
  logic [31:0] o_pc_instr_start_addr;
  logic        o_busy, o_err;
  logic [15:0] o_frame_count;

  s_core_loader #(.TIMEOUT_CYCLES(T), .RESET_START_ADDR(RSA)) dut (
    .clk(clk), .rst(rst),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .i_reload(i_reload), .o_setup(o_setup),
    .o_inst_mem_addr(o_inst_mem_addr), .o_inst_mem_data(o_inst_mem_data), .o_inst_mem_we(o_inst_mem_we),
    .o_load_reg_addr(o_load_reg_addr), .o_load_reg_data(o_load_reg_data), .o_load_reg_we(o_load_reg_we),
    .o_pc_instr_start_addr(o_pc_instr_start_addr), .o_busy(o_busy), .o_err(o_err),
    .o_frame_count(o_frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_reg;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] held_byte;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_reg, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.is_reg = is_reg;
    e.addr   = addr;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one byte at a negedge and hold it until the loader takes it
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!o_rx_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_ready: got rx_ready=0 expected 1 within 20 cycles");
    end
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  // Send tx_q (plus checksum when enabled); optional idle gap before byte gap_at;
  // hold_last leaves the final byte unsent in held_byte
  task automatic send_frame(input bit hold_last, input int gap_at, input int gap_len);
    int n;
`ifdef S_CORE_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (tx_q[i]) x ^= tx_q[i];
    tx_q.push_back(x);
`endif
    n = tx_q.size();
    for (int i = 0; i < n - (hold_last ? 1 : 0); i++) begin
      if (i == gap_at) tick(gap_len);
      send_byte(tx_q[i]);
    end
    held_byte = tx_q[n-1];
  endtask

  // Monitor: every write strobe must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (o_inst_mem_we || o_load_reg_we)) begin
        $display("TXN %s addr=%h data=%h", o_inst_mem_we ? "imem" : "reg",
                 o_inst_mem_we ? o_inst_mem_addr : {27'd0, o_load_reg_addr},
                 o_inst_mem_we ? o_inst_mem_data : o_load_reg_data);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got imem_we=%0d reg_we=%0d expected no strobe",
                   o_inst_mem_we, o_load_reg_we);
        end else begin
          e = exp_q.pop_front();
          chk("sb_kind", {31'd0, o_load_reg_we}, {31'd0, e.is_reg});
          chk("sb_both", {31'd0, o_inst_mem_we & o_load_reg_we}, 32'd0);
          if (e.is_reg) begin
            chk("sb_reg_addr", {27'd0, o_load_reg_addr}, {27'd0, e.addr[4:0]});
            chk("sb_reg_data", o_load_reg_data, e.data);
          end else begin
            chk("sb_imem_addr", o_inst_mem_addr, e.addr);
            chk("sb_imem_data", o_inst_mem_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_reload = 1'b0;
    #1;
    chk("rst_setup", {31'd0, o_setup}, 32'd1);
    chk("rst_ready", {31'd0, o_rx_ready}, 32'd1);
    chk("rst_pc", o_pc_instr_start_addr, RSA);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_fc", {16'd0, o_frame_count}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_we", {30'd0, o_inst_mem_we, o_load_reg_we}, 32'd0);
    chk("rst_iaddr", o_inst_mem_addr, 32'd0);
    tick(2);
    rst = 1'b0;

    // IMEM write
    push_exp(1'b0, 32'h4, 32'h0012_7413);
    tx_q = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h13, 8'h74, 8'h12, 8'h00};
    send_frame(1'b0, -1, 0);
    chk("imem_we_latency", {31'd0, o_inst_mem_we}, 32'd1);
    chk("imem_setup", {31'd0, o_setup}, 32'd1);
    chk("issue_ready", {31'd0, o_rx_ready}, 32'd0);
    tick(1);
    chk("imem_we_oneshot", {31'd0, o_inst_mem_we}, 32'd0);
    chk("imem_fc", {16'd0, o_frame_count}, 32'd1);

    // REG writes, then index 0 (driven, counted, no strobe)
    push_exp(1'b1, 32'd4, 32'd1);
    tx_q = '{8'h02, 8'h04, 8'h01, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0, -1, 0);
    chk("reg_we_latency", {31'd0, o_load_reg_we}, 32'd1);
    tick(1);
    tx_q = '{8'h02, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_frame(1'b0, -1, 0);
    chk("reg0_we", {31'd0, o_load_reg_we}, 32'd0);
    chk("reg0_addr", {27'd0, o_load_reg_addr}, 32'd0);
    chk("reg0_data", o_load_reg_data, 32'hFFFF_FFFF);
    tick(1);
    chk("reg_fc", {16'd0, o_frame_count}, 32'd3);

    // Unknown opcode
    send_byte(8'h7F);
    chk("badop_err", {31'd0, o_err}, 32'd1);
    chk("badop_busy", {31'd0, o_busy}, 32'd0);
    i_reload = 1'b1;
    tick(1);
    i_reload = 1'b0;
    chk("reload_clr_err", {31'd0, o_err}, 32'd0);

    // Stall mid-frame past the timeout
    send_byte(8'h01);
    send_byte(8'h04);
    tick(T + 1);
    chk("tmo_err", {31'd0, o_err}, 32'd1);
    chk("tmo_busy", {31'd0, o_busy}, 32'd0);
    chk("tmo_fc", {16'd0, o_frame_count}, 32'd3);

    // A good frame still writes; error stays sticky
    push_exp(1'b0, 32'h10, 32'hDEAD_BEEF);
    tx_q = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(1'b0, -1, 0);
    chk("post_tmo_we", {31'd0, o_inst_mem_we}, 32'd1);
    tick(1);
    chk("err_sticky", {31'd0, o_err}, 32'd1);

    // Gap of TIMEOUT-1 idle cycles must not abort
    push_exp(1'b0, 32'h20, 32'h1122_3344);
    tx_q = '{8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send_frame(1'b0, 3, T - 1);
    chk("gap_we", {31'd0, o_inst_mem_we}, 32'd1);
    tick(1);
    chk("gap_fc", {16'd0, o_frame_count}, 32'd5);

    // Reload coincident with the last byte: no write
    tx_q = '{8'h01, 8'h30, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(1'b1, -1, 0);
    chk("rl_midframe_busy", {31'd0, o_busy}, 32'd1);
    i_rx_data = held_byte; i_rx_valid = 1'b1; i_reload = 1'b1;
    tick(1);
    i_rx_valid = 1'b0; i_reload = 1'b0;
    chk("rl_we", {31'd0, o_inst_mem_we}, 32'd0);
    chk("rl_setup", {31'd0, o_setup}, 32'd1);
    chk("rl_busy", {31'd0, o_busy}, 32'd0);
    chk("rl_err", {31'd0, o_err}, 32'd0);
    chk("rl_fc", {16'd0, o_frame_count}, 32'd5);
    chk("rl_iaddr_kept", o_inst_mem_addr, 32'h20);
    tick(2);

    // START: address stable while setup is still high, then release
    tx_q = '{8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0, -1, 0);
    chk("start_pc", o_pc_instr_start_addr, 32'h4);
    chk("start_setup", {31'd0, o_setup}, 32'd1);
    chk("start_ready", {31'd0, o_rx_ready}, 32'd0);
    tick(1);
    chk("run_setup", {31'd0, o_setup}, 32'd0);
    chk("run_ready", {31'd0, o_rx_ready}, 32'd0);
    i_rx_data = 8'h01; i_rx_valid = 1'b1;
    tick(5);
    i_rx_valid = 1'b0;
    chk("run_ignore_busy", {31'd0, o_busy}, 32'd0);
    chk("run_ignore_setup", {31'd0, o_setup}, 32'd0);

    // Reload out of RUN
    i_reload = 1'b1;
    tick(1);
    i_reload = 1'b0;
    chk("run_rl_setup", {31'd0, o_setup}, 32'd1);
    chk("run_rl_ready", {31'd0, o_rx_ready}, 32'd1);
    chk("run_rl_pc_kept", o_pc_instr_start_addr, 32'h4);
    push_exp(1'b0, 32'h40, 32'hCAFE_F00D);
    tx_q = '{8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    send_frame(1'b0, -1, 0);
    chk("after_run_we", {31'd0, o_inst_mem_we}, 32'd1);
    tick(1);

`ifdef S_CORE_LOADER_CHECKSUM_EN
    // Correct checksum writes, wrong checksum is rejected
    push_exp(1'b0, 32'h8, 32'h0060_0033);
    tx_q = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h60, 8'h00};
    send_frame(1'b0, -1, 0);
    chk("csum_ok_we", {31'd0, o_inst_mem_we}, 32'd1);
    tick(1);
    tx_q = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h60, 8'h00};
    foreach (tx_q[i]) send_byte(tx_q[i]);
    send_byte(8'h00);
    chk("csum_bad_we", {31'd0, o_inst_mem_we}, 32'd0);
    chk("csum_bad_err", {31'd0, o_err}, 32'd1);
    chk("csum_bad_busy", {31'd0, o_busy}, 32'd0);
    tick(1);
`endif

    tick(3);
    chk("sb_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-frame
    send_byte(8'h01);
    send_byte(8'h04);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_fc", {16'd0, o_frame_count}, 32'd0);
    chk("arst_pc", o_pc_instr_start_addr, RSA);
    chk("arst_setup", {31'd0, o_setup}, 32'd1);
    tick(1);
    rst = 1'b0;
    tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
